pool1_max2x2: RTL and testbench
===============================

Name: pool1_max2x2

Overview:
- Streaming 2x2, stride-2 max-pool stage directly downstream of the first conv layer.
- Consumes the conv layer's per-pixel output vector: CH channels of WIDTH bits, already ReLU'd and bias-added, in raster order over a W_IN x H_IN map.
- Produces a W_IN/2 x H_IN/2 x CH pooled map with a linear write address for the next layer's feature-map RAM.
- Uses one half-width line buffer, so each pixel is consumed exactly once.

Parameters:
- CH, 64, channels per pixel beat (one comparator lane per channel).
- WIDTH, 16, bits per channel value; values are unsigned, because the upstream stage clamps negatives to 0.
- W_IN, 128, input map width; must be even.
- H_IN, 128, input map height; must be even.
- ADDR_W, $clog2((W_IN/2)*(H_IN/2)), width of the output address.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- pool_start  input  1  single-cycle pulse; starts or restarts a frame.
- in_valid  input  1  the current pixel vector is valid this cycle; no backpressure.
- ofm_in  input  CH x WIDTH  pixel vector (unpacked array [0:CH-1] of WIDTH).
- out_valid  output  1  one-cycle pulse; pooled vector valid.
- pool_out  output  CH x WIDTH  pooled vector (unpacked array [0:CH-1] of WIDTH).
- out_addr  output  ADDR_W  linear address of pool_out: orow*(W_IN/2)+ocol.
- pool_busy  output  1  high while in RUN.
- pool_end  output  1  sticky; high once the frame completes, until the next pool_start or reset.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; col=0, row=0.
  - out_valid=0, pool_out all 0, out_addr=0, pool_busy=0, pool_end=0.
  - Even-column register and line buffer contents are don't-care; they are never read before being written.
- States: IDLE -> RUN on pool_start. RUN -> DONE when the last output is issued. DONE -> RUN on pool_start.
- In IDLE and DONE, in_valid is ignored.
- pool_start in any state, including mid-frame in RUN:
  - Next cycle: col=0, row=0, pool_end=0, out_valid=0, state=RUN.
  - A partial frame is discarded; an in_valid on the same cycle as pool_start is ignored.
- Counters:
  - On each accepted beat (RUN and in_valid), col increments; at W_IN-1 it wraps to 0 and row increments.
  - Gaps in in_valid stall the counters; no data is lost.
- Per accepted beat, per channel c:
  - Even col: even_reg[c] <= ofm_in[c].
  - Odd col: h = max(even_reg[c], ofm_in[c]), unsigned compare.
    - Even row: linebuf[col>>1][c] <= h.
    - Odd row: pool_out[c] <= max(linebuf[col>>1][c], h).
    - Odd row also sets out_valid <= 1 and out_addr <= (row>>1)*(W_IN/2)+(col>>1).
- Latency: out_valid is asserted on the cycle after the completing beat (odd row, odd col), for exactly one cycle.
- pool_out and out_addr hold their values until the next output.
- Equal values: max returns that value; no tie semantics beyond that.
- Frame end:
  - The beat at row=H_IN-1, col=W_IN-1 produces the final output, with out_addr=(W_IN/2)*(H_IN/2)-1.
  - On the same edge that asserts that out_valid, the block sets pool_end=1 and pool_busy=0 and enters DONE.
  - Exactly (W_IN/2)*(H_IN/2) outputs are produced per frame.
- The line buffer holds W_IN/2 entries of CH*WIDTH bits.
  - It has one write port and one read port, and a write and a read never target the same entry in the same cycle.
  - Either flops or inferred RAM with asynchronous read is allowed.
- Reset asserted mid-frame: immediate return to reset values; no output pulse is generated.

Test Plan:
- Reset with pool_start held 0 -> out_valid=0, pool_busy=0, pool_end=0, pool_out all 0, and all of them stay there under in_valid toggling.
- W_IN=H_IN=4, CH=2:
  - Stimulus: pool_start, then 16 contiguous beats, channel 0 = raster index 0..15, channel 1 = 15-index.
  - Required: 4 outputs at addresses 0,1,2,3.
  - ch0 = 5,7,13,15; ch1 = 15,13,7,5.
  - Each output appears 1 cycle after beats 5,7,13,15; pool_end rises with the 4th output.
- Default params, random values in 0..0xFFFF with random in_valid gaps (about 30% idle) -> 4096 outputs; every value matches a reference model; out_addr runs 0..4095 monotonically.
- Tie and max-value check: a 2x2 block whose values are all 0xFFFF, and a block with duplicates {3,3,1,0} -> outputs 0xFFFF and 3.
- Restart: pool_start after 150 beats, then a full frame -> no output from the aborted partial frame; the new frame starts at out_addr=0 with correct values; exactly 4096 outputs.
- Async reset asserted mid-output-row -> all outputs 0 immediately, before the next clk edge; after reset release plus pool_start, a full frame is correct.

Source files
------------

// File: rtl/pool1_max2x2.sv
// pool1_max2x2: streaming 2x2 / stride-2 max-pool over a raster-ordered
// W_IN x H_IN x CH map of unsigned WIDTH-bit values. A half-width line
// buffer holds the horizontal maxima of each even row. Each odd row combines
// them with its own horizontal maxima to emit one pooled vector per 2x2 block.
module pool1_max2x2 #(
    parameter int CH     = 64,
    parameter int WIDTH  = 16,
    parameter int W_IN   = 128,
    parameter int H_IN   = 128,
    parameter int ADDR_W = $clog2((W_IN / 2) * (H_IN / 2))
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pool_start,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  ofm_in [0:CH-1],
    output logic              out_valid,
    output logic [WIDTH-1:0]  pool_out [0:CH-1],
    output logic [ADDR_W-1:0] out_addr,
    output logic              pool_busy,
    output logic              pool_end
);

    localparam int HALF_W = W_IN / 2;
    localparam int COL_W  = (W_IN > 1) ? $clog2(W_IN) : 1;
    localparam int ROW_W  = (H_IN > 1) ? $clog2(H_IN) : 1;
    localparam int LB_W   = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             accept;
    logic             col_last;
    logic             row_last;
    logic             frame_last;
    logic [LB_W-1:0]  lb_idx;

    logic [WIDTH-1:0] even_reg [0:CH-1];
    logic [WIDTH-1:0] linebuf  [0:HALF_W-1][0:CH-1];
    logic [WIDTH-1:0] hmax     [0:CH-1];
    logic [WIDTH-1:0] vmax     [0:CH-1];

    // A beat counts only in RUN; a start pulse wins over a beat on the same cycle.
    assign accept     = (state == RUN) && in_valid && !pool_start;
    assign col_last   = (col == COL_W'(W_IN - 1));
    assign row_last   = (row == ROW_W'(H_IN - 1));
    assign frame_last = col_last && row_last;
    assign lb_idx     = LB_W'(col >> 1);

    assign pool_busy = (state == RUN);
    assign pool_end  = (state == DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registers take non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: any start pulse (re)enters RUN; the final beat ends the frame.
    always_comb begin
        state_nxt = state;
        if (pool_start)
            state_nxt = RUN;
        else if (accept && frame_last)
            state_nxt = DONE;
    end

    // Per-channel comparators: horizontal max of the pixel pair, then vertical
    // max against the stored even-row result. Read and write entries never
    // collide because reads happen only on odd rows and writes only on even rows.
    always_comb begin
        // NOTE: every element is assigned on every pass, so no latch is inferred.
        for (int c = 0; c < CH; c++) begin
            hmax[c] = (ofm_in[c] > even_reg[c]) ? ofm_in[c] : even_reg[c];
            vmax[c] = (linebuf[lb_idx][c] > hmax[c]) ? linebuf[lb_idx][c] : hmax[c];
        end
    end

    // Pixel-pair and line-buffer storage, written only by accepted beats.
    always_ff @(posedge clk) begin
        // NOTE: no reset on these arrays; each entry is written before it is
        // read in every frame, so resetting them would only cost logic.
        if (accept) begin
            if (!col[0]) begin
                for (int c = 0; c < CH; c++) even_reg[c] <= ofm_in[c];
            end else if (!row[0]) begin
                for (int c = 0; c < CH; c++) linebuf[lb_idx][c] <= hmax[c];
            end
        end
    end

    // Raster counters and the registered output vector, address and strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            for (int c = 0; c < CH; c++) pool_out[c] <= '0;
        end else begin
            out_valid <= 1'b0;
            if (pool_start) begin
                col <= '0;
                row <= '0;
            end else if (accept) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (col[0] && row[0]) begin
                    out_valid <= 1'b1;
                    out_addr  <= ADDR_W'(int'(row >> 1) * HALF_W + int'(col >> 1));
                    for (int c = 0; c < CH; c++) pool_out[c] <= vmax[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_pool1_max2x2.sv
// Bench for pool1_max2x2: a small 4x4x2 instance for the directed raster and
// tie cases, and a default-size instance for random frames, restart and
// mid-frame reset. Drivers push expected blocks into per-instance queues at
// the moment the completing beat is issued; monitors pop and compare.
module tb_pool1_max2x2;

    localparam int BCH = 64;
    localparam int BW  = 128;
    localparam int BH  = 128;
    localparam int BAW = 12;
    localparam int SCH = 2;
    localparam int SW  = 4;
    localparam int SH  = 4;
    localparam int SAW = 2;

    typedef struct {
        int           addr;
        int           edge_no;
        bit           last;
        logic [1023:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edge_cnt  = 0;
    int   n_cmp     = 0;
    int   n_bad     = 0;
    int   b_out_cnt = 0;
    int   s_out_cnt = 0;
    exp_t bq[$];
    exp_t sq[$];

    logic           b_start, b_in_valid, b_out_valid, b_busy, b_end;
    logic [15:0]    b_in [0:BCH-1];
    logic [15:0]    b_pool_out [0:BCH-1];
    logic [BAW-1:0] b_out_addr;

    logic           s_start, s_in_valid, s_out_valid, s_busy, s_end;
    logic [15:0]    s_in [0:SCH-1];
    logic [15:0]    s_pool_out [0:SCH-1];
    logic [SAW-1:0] s_out_addr;

    // Frame images as driven: the reference model pools directly over these.
    logic [15:0] b_img [0:BH-1][0:BW-1][0:BCH-1];
    logic [15:0] s_img [0:SH-1][0:SW-1][0:SCH-1];

    pool1_max2x2 u_big (
        .clk       (clk),
        .rst       (rst),
        .pool_start(b_start),
        .in_valid  (b_in_valid),
        .ofm_in    (b_in),
        .out_valid (b_out_valid),
        .pool_out  (b_pool_out),
        .out_addr  (b_out_addr),
        .pool_busy (b_busy),
        .pool_end  (b_end)
    );

    pool1_max2x2 #(.CH(SCH), .WIDTH(16), .W_IN(SW), .H_IN(SH)) u_small (
        .clk       (clk),
        .rst       (rst),
        .pool_start(s_start),
        .in_valid  (s_in_valid),
        .ofm_in    (s_in),
        .out_valid (s_out_valid),
        .pool_out  (s_pool_out),
        .out_addr  (s_out_addr),
        .pool_busy (s_busy),
        .pool_end  (s_end)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] max4(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c, input logic [15:0] d);
        logic [15:0] m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic logic [15:0] b_or();
        logic [15:0] acc;
        acc = '0;
        for (int ch = 0; ch < BCH; ch++) acc = acc | b_pool_out[ch];
        return acc;
    endfunction

    // Monitor for the default-size instance.
    always @(negedge clk) begin : mon_big
        exp_t e;
        int   k;
        bit   found;
        if (!rst && b_out_valid) begin
            b_out_cnt++;
            if (bq.size() == 0) begin
                check("big_unexpected_out", 32'(b_out_addr), 32'hFFFF_FFFF);
            end else begin
                e     = bq.pop_front();
                k     = 0;
                found = 1'b0;
                for (int ch = 0; ch < BCH; ch++)
                    if (!found && b_pool_out[ch] !== e.data[ch*16 +: 16]) begin
                        k     = ch;
                        found = 1'b1;
                    end
                check("big_addr", 32'(b_out_addr), e.addr);
                check("big_data", 32'(b_pool_out[k]), 32'(e.data[k*16 +: 16]));
                check("big_latency", edge_cnt, e.edge_no);
                check("big_end_flag", 32'(b_end), 32'(e.last));
                check("big_busy_flag", 32'(b_busy), 32'(!e.last));
            end
        end
    end

    // Monitor for the 4x4x2 instance.
    always @(negedge clk) begin : mon_small
        exp_t e;
        if (!rst && s_out_valid) begin
            s_out_cnt++;
            if (sq.size() == 0) begin
                check("small_unexpected_out", 32'(s_out_addr), 32'hFFFF_FFFF);
            end else begin
                e = sq.pop_front();
                check("small_addr", 32'(s_out_addr), e.addr);
                check("small_ch0", 32'(s_pool_out[0]), 32'(e.data[15:0]));
                check("small_ch1", 32'(s_pool_out[1]), 32'(e.data[31:16]));
                check("small_latency", edge_cnt, e.edge_no);
                check("small_end_flag", 32'(s_end), 32'(e.last));
                check("small_busy_flag", 32'(s_busy), 32'(!e.last));
            end
        end
    end

    // Small frame: mode 0 = raster index / 15-index, mode 1 = tie blocks.
    task automatic small_frame(input bit ties);
        int   r, c;
        exp_t e;
        @(posedge clk); #1;
        s_start    = 1'b1;
        s_in_valid = 1'b1;
        s_in[0]    = 16'hDEAD;
        s_in[1]    = 16'hBEEF;
        for (int i = 0; i < SW * SH; i++) begin
            @(posedge clk); #1;
            s_start = 1'b0;
            if (i == 0) s_out_cnt = 0;
            r = i / SW;
            c = i % SW;
            for (int ch = 0; ch < SCH; ch++) begin
                if (!ties)
                    s_img[r][c][ch] = (ch == 0) ? 16'(i) : 16'(15 - i);
                else if (r < 2 && c < 2)
                    s_img[r][c][ch] = 16'hFFFF;
                else if (r < 2)
                    s_img[r][c][ch] = (r == 0) ? 16'd3 : ((c == 2) ? 16'd1 : 16'd0);
                else
                    s_img[r][c][ch] = 16'($urandom);
                s_in[ch] = s_img[r][c][ch];
            end
            s_in_valid = 1'b1;
            if (r % 2 == 1 && c % 2 == 1) begin
                e.addr    = (r / 2) * (SW / 2) + c / 2;
                e.edge_no = edge_cnt + 1;
                e.last    = (i == SW * SH - 1);
                e.data    = '0;
                for (int ch = 0; ch < SCH; ch++)
                    e.data[ch*16 +: 16] = max4(s_img[r-1][c-1][ch], s_img[r-1][c][ch],
                                               s_img[r][c-1][ch], s_img[r][c][ch]);
                sq.push_back(e);
            end
        end
        @(posedge clk); #1;
        s_in_valid = 1'b0;
    endtask

    // Big frame: start pulse (with an ignored beat), then nbeats beats with
    // roughly idle_pct percent idle cycles carrying random junk.
    task automatic big_frame(input int nbeats, input int idle_pct);
        int   b     = 0;
        bit   fresh = 1'b1;
        int   r, c;
        exp_t e;
        @(posedge clk); #1;
        b_start    = 1'b1;
        b_in_valid = 1'b1;
        for (int ch = 0; ch < BCH; ch++) b_in[ch] = 16'($urandom);
        while (b < nbeats) begin
            @(posedge clk); #1;
            b_start = 1'b0;
            if (fresh) begin
                b_out_cnt = 0;
                fresh     = 1'b0;
            end
            for (int ch = 0; ch < BCH; ch++) b_in[ch] = 16'($urandom);
            if ($urandom_range(0, 99) < idle_pct) begin
                b_in_valid = 1'b0;
            end else begin
                r = b / BW;
                c = b % BW;
                for (int ch = 0; ch < BCH; ch++) b_img[r][c][ch] = b_in[ch];
                b_in_valid = 1'b1;
                if (r % 2 == 1 && c % 2 == 1) begin
                    e.addr    = (r / 2) * (BW / 2) + c / 2;
                    e.edge_no = edge_cnt + 1;
                    e.last    = (r == BH - 1) && (c == BW - 1);
                    e.data    = '0;
                    for (int ch = 0; ch < BCH; ch++)
                        e.data[ch*16 +: 16] = max4(b_img[r-1][c-1][ch], b_img[r-1][c][ch],
                                                   b_img[r][c-1][ch], b_img[r][c][ch]);
                    bq.push_back(e);
                end
                b++;
            end
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while ((bq.size() != 0 || sq.size() != 0) && t < 20) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk); #1;
        check({tag, "_pending_big"}, bq.size(), 0);
        check({tag, "_pending_small"}, sq.size(), 0);
    endtask

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        b_start    = 1'b0;
        b_in_valid = 1'b0;
        s_start    = 1'b0;
        s_in_valid = 1'b0;
        for (int ch = 0; ch < BCH; ch++) b_in[ch] = '0;
        for (int ch = 0; ch < SCH; ch++) s_in[ch] = '0;

        // Reset values, then idle behaviour with in_valid toggling and no start.
        #12;
        check("rst_out_valid", 32'(b_out_valid), 0);
        check("rst_busy", 32'(b_busy), 0);
        check("rst_end", 32'(b_end), 0);
        check("rst_pool_out", 32'(b_or()), 0);
        check("rst_out_addr", 32'(b_out_addr), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            b_in_valid = i[0];
            s_in_valid = !i[0];
            for (int ch = 0; ch < BCH; ch++) b_in[ch] = 16'($urandom);
            for (int ch = 0; ch < SCH; ch++) s_in[ch] = 16'($urandom);
            check("idle_out_valid", 32'(b_out_valid), 0);
            check("idle_busy", 32'(b_busy), 0);
            check("idle_end", 32'(b_end), 0);
            check("idle_pool_out", 32'(b_or()), 0);
            check("idle_small_valid", 32'(s_out_valid), 0);
        end
        b_in_valid = 1'b0;
        s_in_valid = 1'b0;

        // 4x4x2 raster frame, then a frame holding the all-max and duplicate blocks.
        small_frame(1'b0);
        drain("small_raster");
        check("small_raster_count", s_out_cnt, 4);
        check("small_raster_end", 32'(s_end), 1);
        check("small_raster_busy", 32'(s_busy), 0);
        small_frame(1'b1);
        drain("small_ties");
        check("small_ties_count", s_out_cnt, 4);
        check("small_ties_end", 32'(s_end), 1);

        // Full random frame with idle gaps.
        big_frame(BW * BH, 30);
        drain("big_random");
        check("big_random_count", b_out_cnt, (BW / 2) * (BH / 2));
        check("big_random_end", 32'(b_end), 1);
        check("big_random_busy", 32'(b_busy), 0);

        // Partial frame aborted by a new start, then a complete frame.
        big_frame(150, 0);
        drain("big_partial");
        check("big_partial_busy", 32'(b_busy), 1);
        check("big_partial_end", 32'(b_end), 0);
        big_frame(BW * BH, 0);
        drain("big_restart");
        check("big_restart_count", b_out_cnt, (BW / 2) * (BH / 2));
        check("big_restart_end", 32'(b_end), 1);

        // Asynchronous reset in the middle of an output row.
        big_frame(3 * BW + 41, 20);
        #1;
        check("pre_rst_busy", 32'(b_busy), 1);
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(b_out_valid), 0);
        check("async_rst_pool_out", 32'(b_or()), 0);
        check("async_rst_out_addr", 32'(b_out_addr), 0);
        check("async_rst_busy", 32'(b_busy), 0);
        check("async_rst_end", 32'(b_end), 0);
        bq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        big_frame(BW * BH, 10);
        drain("big_after_rst");
        check("big_after_rst_count", b_out_cnt, (BW / 2) * (BH / 2));
        check("big_after_rst_end", 32'(b_end), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
